// File: rtl/noc_credit_counter.sv
// noc_credit_counter
// Per-output-port credit tracker for the 5-port mesh router. Each port keeps a
// saturating count of free slots in the neighbouring router's input FIFO.
// The FCU grants an output only while that port's credit_en_o bit is high.
//
// Ports (bit order of every 5-bit vector: [0]=N [1]=S [2]=E [3]=W [4]=L)
//   clk              system clock, rising-edge
//   rst_n            asynchronous active-low reset
//   flit_sent_i      flit left on the port this cycle (consumes a credit)
//   credit_ret_i     downstream freed a slot this cycle (returns a credit)
//   err_clr_i        synchronous clear of both sticky error vectors
//   credit_en_o      port has at least one credit
//   credit_cnt_o     packed counters, port p at [p*CNT_W +: CNT_W]
//   err_underflow_o  sticky: flit sent with zero credits
//   err_overflow_o   sticky: credit returned with the count already full
module noc_credit_counter #(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           flit_sent_i,
    input  logic [4:0]           credit_ret_i,
    input  logic                 err_clr_i,
    output logic [4:0]           credit_en_o,
    output logic [5*CNT_W-1:0]   credit_cnt_o,
    output logic [4:0]           err_underflow_o,
    output logic [4:0]           err_overflow_o
);

    localparam int unsigned NPORT = 5;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [NPORT*CNT_W-1:0] cnt_q;
    logic [NPORT*CNT_W-1:0] cnt_d;
    logic [NPORT-1:0]       en_d;
    logic [NPORT-1:0]       unf_d;
    logic [NPORT-1:0]       ovf_d;

    // Next-state: independent saturating counter per port plus sticky errors.
    // A clear is applied before the new events so a same-cycle set wins.
    always_comb begin
        cnt_d = cnt_q;
        en_d  = '0;
        unf_d = err_underflow_o & ~{NPORT{err_clr_i}};
        ovf_d = err_overflow_o  & ~{NPORT{err_clr_i}};
        for (int unsigned p = 0; p < NPORT; p++) begin
            unique case ({flit_sent_i[p], credit_ret_i[p]})
                2'b10: begin
                    if (cnt_q[p*CNT_W +: CNT_W] == '0) begin
                        unf_d[p] = 1'b1;
                    end else begin
                        cnt_d[p*CNT_W +: CNT_W] = cnt_q[p*CNT_W +: CNT_W] - ONE;
                    end
                end
                2'b01: begin
                    if (cnt_q[p*CNT_W +: CNT_W] == DEPTH) begin
                        ovf_d[p] = 1'b1;
                    end else begin
                        cnt_d[p*CNT_W +: CNT_W] = cnt_q[p*CNT_W +: CNT_W] + ONE;
                    end
                end
                default: ;  // send+return cancel, or idle
            endcase
            // Enable is registered from the next count so it always equals
            // (cnt != 0) of the counter register with no extra latency.
            en_d[p] = (cnt_d[p*CNT_W +: CNT_W] != '0);
        end
    end

    // State registers; reset fills every port with a full credit budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= {NPORT{DEPTH}};
            credit_en_o     <= (BUF_DEPTH != 0) ? {NPORT{1'b1}} : '0;
            err_underflow_o <= '0;
            err_overflow_o  <= '0;
        end else begin
            cnt_q           <= cnt_d;
            credit_en_o     <= en_d;
            err_underflow_o <= unf_d;
            err_overflow_o  <= ovf_d;
        end
    end

    assign credit_cnt_o = cnt_q;

endmodule

// File: tb/tb_noc_credit_counter.sv
// Self-checking bench for noc_credit_counter: directed test-plan steps followed
// by random traffic, compared against a per-port integer reference model.
module tb_noc_credit_counter;

    localparam int CNT_W = 3;
    localparam int DEPTH = 4;

    logic               clk;
    logic               rst_n;
    logic [4:0]         flit_sent;
    logic [4:0]         credit_ret;
    logic               err_clr;
    logic [4:0]         credit_en;
    logic [5*CNT_W-1:0] credit_cnt;
    logic [4:0]         err_underflow;
    logic [4:0]         err_overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_cnt [5];
    bit m_unf [5];
    bit m_ovf [5];

    noc_credit_counter #(.BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flit_sent_i     (flit_sent),
        .credit_ret_i    (credit_ret),
        .err_clr_i       (err_clr),
        .credit_en_o     (credit_en),
        .credit_cnt_o    (credit_cnt),
        .err_underflow_o (err_underflow),
        .err_overflow_o  (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int p = 0; p < 5; p++) begin
            m_cnt[p] = DEPTH;
            m_unf[p] = 1'b0;
            m_ovf[p] = 1'b0;
        end
    endfunction

    function automatic void m_update(input logic [4:0] s, input logic [4:0] r, input logic c);
        for (int p = 0; p < 5; p++) begin
            if (c) begin
                m_unf[p] = 1'b0;
                m_ovf[p] = 1'b0;
            end
            if (s[p] && !r[p]) begin
                if (m_cnt[p] > 0) m_cnt[p] = m_cnt[p] - 1;
                else m_unf[p] = 1'b1;
            end else if (r[p] && !s[p]) begin
                if (m_cnt[p] < DEPTH) m_cnt[p] = m_cnt[p] + 1;
                else m_ovf[p] = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [5*CNT_W-1:0] e_cnt;
        logic [4:0] e_en, e_unf, e_ovf;
        for (int p = 0; p < 5; p++) begin
            e_cnt[p*CNT_W +: CNT_W] = CNT_W'(m_cnt[p]);
            e_en[p]  = (m_cnt[p] != 0);
            e_unf[p] = m_unf[p];
            e_ovf[p] = m_ovf[p];
        end
        chk({tag, "_cnt"}, 32'(credit_cnt), 32'(e_cnt));
        chk({tag, "_en"},  32'(credit_en),  32'(e_en));
        chk({tag, "_unf"}, 32'(err_underflow), 32'(e_unf));
        chk({tag, "_ovf"}, 32'(err_overflow),  32'(e_ovf));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cnt"}, 32'(credit_cnt), 32'(15'b100_100_100_100_100));
        chk({tag, "_en"},  32'(credit_en), 32'h1f);
        chk({tag, "_unf"}, 32'(err_underflow), 32'h0);
        chk({tag, "_ovf"}, 32'(err_overflow), 32'h0);
    endtask

    // Drive one cycle of inputs at the falling edge, check 1 ns after the rise.
    task automatic step(input string tag, input logic [4:0] s, input logic [4:0] r, input logic c);
        @(negedge clk);
        flit_sent  = s;
        credit_ret = r;
        err_clr    = c;
        @(posedge clk);
        m_update(s, r, c);
        #1;
        check_model(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        flit_sent  = '0;
        credit_ret = '0;
        err_clr    = 1'b0;
        rst_n      = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        flit_sent  = '0;
        credit_ret = '0;
        err_clr    = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_values("reset");
        release_reset();

        // Drain north one credit per edge
        for (int i = 0; i < 4; i++) step("drain_n", 5'b00001, 5'b00000, 1'b0);
        chk("drain_n_en0_low", 32'(credit_en[0]), 32'h0);
        chk("drain_n_others", 32'(credit_cnt[14:3]), 32'(12'b100_100_100_100));

        // Underflow then recovery; error stays sticky until cleared
        step("unf", 5'b00001, 5'b00000, 1'b0);
        chk("unf_flag", 32'(err_underflow[0]), 32'h1);
        step("unf_ret", 5'b00000, 5'b00001, 1'b0);
        chk("unf_ret_en", 32'(credit_en[0]), 32'h1);
        step("unf_hold", 5'b00000, 5'b00000, 1'b0);
        step("unf_clr", 5'b00000, 5'b00000, 1'b1);

        // Simultaneous send+return at empty and at full
        for (int i = 0; i < 4; i++) step("drain_e", 5'b00100, 5'b00000, 1'b0);
        for (int i = 0; i < 3; i++) step("sim_e0", 5'b00100, 5'b00100, 1'b0);
        for (int i = 0; i < 4; i++) step("fill_e", 5'b00000, 5'b00100, 1'b0);
        for (int i = 0; i < 3; i++) step("sim_e4", 5'b00100, 5'b00100, 1'b0);

        // Overflow on local; a clear coinciding with a new overflow keeps the bit
        step("ovf", 5'b00000, 5'b10000, 1'b0);
        chk("ovf_flag", 32'(err_overflow[4]), 32'h1);
        step("ovf_clr_set", 5'b00000, 5'b10000, 1'b1);
        chk("ovf_set_wins", 32'(err_overflow[4]), 32'h1);
        step("ovf_clr", 5'b00000, 5'b00000, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 5'($urandom), 5'($urandom), ($urandom_range(0, 7) == 0));
        end

        // Build counts (0,2,3,1,4) with pending errors
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #1 check_reset_values("rst2");
        release_reset();
        step("mix1", 5'b01111, 5'b00000, 1'b0);
        step("mix2", 5'b01011, 5'b00000, 1'b0);
        step("mix3", 5'b01001, 5'b00000, 1'b0);
        step("mix4", 5'b00001, 5'b00000, 1'b0);
        step("mix5", 5'b00001, 5'b10000, 1'b0);
        chk("mix_cnt", 32'(credit_cnt), 32'(15'b100_001_011_010_000));

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        m_reset();
        #1 check_reset_values("async_rst");
        flit_sent  = 5'b11111;
        credit_ret = 5'b00000;
        @(posedge clk);
        #1 check_reset_values("rst_ignores_in");
        release_reset();
        step("post_rst", 5'b00010, 5'b00000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global timeout guard
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
